// File: rtl/serial_parity_accumulator.sv
// serial_parity_accumulator
// Bit-serial frame checker: XOR-reduces each framed 1-bit stream into a
// parity bit, counts the frame length (saturating at MAX_LEN, with an
// overflow flag) and presents one result per frame on a valid/ready port
// backed by a single-entry result buffer.
module serial_parity_accumulator #(
  parameter int MAX_LEN = 16,
  // Derived width of the length fields; leave at its default.
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_parity,
  output logic [CNT_W-1:0] down_len,
  output logic             down_overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  // Running accumulators for the frame in progress. They are zero whenever
  // no frame is in progress (IDLE and HOLD), so a new frame never inherits
  // anything from the previous one.
  logic             acc_parity;
  logic [CNT_W-1:0] acc_len;
  logic             acc_ovf;

  logic             accept;
  logic             take;
  logic             len_sat;
  logic             frame_parity;
  logic [CNT_W-1:0] frame_len;
  logic             frame_ovf;

  // The pending result blocks the input only while it is not being taken;
  // when down_ready is high the buffer frees up in this very cycle, so the
  // input may be accepted alongside the handshake.
  assign up_ready = (state == HOLD) ? down_ready : 1'b1;
  assign accept   = up_valid && up_ready;
  assign take     = (state == HOLD) && down_ready;

  // Accumulator values once the bit on up_data is folded in.
  assign len_sat      = (acc_len == LEN_MAX);
  assign frame_parity = acc_parity ^ up_data;
  assign frame_len    = len_sat ? acc_len : acc_len + CNT_W'(1);
  assign frame_ovf    = acc_ovf | len_sat;

  // Next-state decode for the frame / result-buffer FSM.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) state_nxt = up_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (take) begin
          if (accept) state_nxt = up_last ? HOLD : ACCUM;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame accumulators: fold in each accepted bit, clear at end of frame.
  always_ff @(posedge clk) begin
    if (rst || (accept && up_last)) begin
      acc_parity <= 1'b0;
      acc_len    <= '0;
      acc_ovf    <= 1'b0;
    end else if (accept) begin
      acc_parity <= frame_parity;
      acc_len    <= frame_len;
      acc_ovf    <= frame_ovf;
    end
  end

  // Result buffer: load on the last bit, drop valid once taken with nothing
  // new to show; fields keep their last values after a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      down_valid    <= 1'b0;
      down_parity   <= 1'b0;
      down_len      <= '0;
      down_overflow <= 1'b0;
    end else if (accept && up_last) begin
      down_valid    <= 1'b1;
      down_parity   <= frame_parity;
      down_len      <= frame_len;
      down_overflow <= frame_ovf;
    end else if (take) begin
      down_valid    <= 1'b0;
    end
  end

endmodule

// File: doc/serial_parity_accumulator.md
Name: serial_parity_accumulator

Overview:
- Bit-serial stage downstream of the XOR/mux gate-level blocks.
- Consumes a framed 1-bit stream, XOR-reduces each frame into a parity bit, and counts the frame length.
- Emits one result per frame on a valid/ready output with a single-entry result buffer.
- Used to check gate-level XOR outputs against a sequential reference in later labs.

Parameters:
- MAX_LEN, 16, maximum counted frame length in bits; the counter saturates here.
- CNT_W, $clog2(MAX_LEN+1), width of the length fields (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- up_valid  input  1  upstream bit valid.
- up_ready  output  1  block can accept a bit this cycle.
- up_data  input  1  stream bit.
- up_last  input  1  marks the final bit of a frame.
- down_valid  output  1  frame result available.
- down_ready  input  1  downstream accepts the result.
- down_parity  output  1  XOR of all bits in the frame (1 = odd number of ones).
- down_len  output  CNT_W  accepted bit count, saturating at MAX_LEN.
- down_overflow  output  1  frame had more than MAX_LEN bits.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; acc_parity=0, acc_len=0, acc_ovf=0; down_valid=0, down_parity=0, down_len=0, down_overflow=0.
- Reset mid-frame: any partial frame or pending result is discarded at the clock edge where rst=1.
- States:
  - IDLE: no frame in progress.
  - ACCUM: at least one bit of the current frame accepted.
  - HOLD: a result is pending on the down port.
- Accept condition: up_valid && up_ready. up_data and up_last are ignored otherwise.
- up_ready = 1 in IDLE/ACCUM; up_ready = down_ready in HOLD. This is a combinational pass-through, so a new bit may be accepted in the same cycle the pending result is taken.
- down_valid is registered and never depends combinationally on down_ready.
- On accept without up_last:
  - acc_parity ^= up_data.
  - acc_len++ if acc_len < MAX_LEN; otherwise acc_len holds and acc_ovf := 1.
  - Next state is ACCUM.
- On accept with up_last:
  - Output registers load the final values, including this bit: parity = acc_parity^up_data; len = saturating acc_len+1; overflow = acc_ovf, or 1 if this bit exceeded MAX_LEN.
  - Accumulators clear; next state is HOLD; down_valid=1 on the next cycle (latency 1 cycle from the last accepted bit).
- A one-bit frame (up_last on the first bit) is legal: len=1, parity=up_data.
- HOLD with down_ready=0: down_valid and all down_* fields hold stable; no input is accepted.
- HOLD with down_ready=1 (handshake):
  - If a bit is accepted that cycle without up_last: go to ACCUM, down_valid=0 next cycle.
  - If the accepted bit has up_last: stay in HOLD and load the new result, so down_valid stays 1 with no bubble.
  - If no bit is accepted: go to IDLE, down_valid=0 next cycle.
- Outputs retain their last values after a handshake (only down_valid drops); they are don't-care while down_valid=0.
- Accumulators never carry across frames; a first bit in IDLE or HOLD starts from parity 0, len 0, ovf 0.

Test Plan:
1. Reset: rst=1 for 2 cycles with random up_* values -> down_valid=0, down_parity=0, down_len=0, down_overflow=0, up_ready=1.
2. Frame 1,0,1,1 (last on the 4th), down_ready=1 -> down_valid=1 exactly one cycle after the 4th accept, parity=1, len=4, overflow=0, then down_valid drops.
3. Backpressure: frame 1,1, down_ready=0 for 5 cycles -> down_valid=1, parity=0, len=2 held stable, up_ready=0. Then down_ready=1 with up_valid=1, data=1 -> handshake and bit accepted in the same cycle; the next frame's parity starts from that bit.
4. Back-to-back one-bit frames (data=1, last=1, up_valid=1 every cycle, down_ready=1) for 8 cycles -> down_valid continuously 1 from cycle 2, 8 results with parity=1, len=1, no bubbles or drops.
5. Overflow with MAX_LEN=16: 20 bits all 1, last on the 20th -> len=16, overflow=1, parity=0. Next frame 1,0 -> len=2, overflow=0, parity=1.
6. Reset mid-frame: 3 bits of 1, then rst=1 for 1 cycle, then frame 1,1 -> single result parity=0, len=2, overflow=0; no stale result appears.
